rf_mport: RTL and testbench
===========================

RF_MPORT -- requirements
Module: rf_mport

Interface
REQ-001 SHALL have parameter DW, default 32, meaning data width in bits.
REQ-002 SHALL have parameter NREG, default 32, meaning register count (power of two, at least 2); RAW = $clog2(NREG) is the address width.
REQ-003 SHALL have parameter NRD, default 2, meaning read port count (1..4).
REQ-004 SHALL have parameter NWR, default 1, meaning write port count (1..2).
REQ-005 SHALL have parameter BYPASS, default 1, meaning 1 enables same-cycle write-to-read forwarding.
REQ-006 SHALL have port clk, input, 1, meaning the single clock.
REQ-007 SHALL have port rst_n, input, 1, meaning reset: asynchronous, active-low.
REQ-008 SHALL have port wr_en, input, [NWR], meaning write enable per write port.
REQ-009 SHALL have port rd_addr, input, [NWR][RAW], meaning destination register per write port.
REQ-010 SHALL have port rd_data, input, [NWR][DW], meaning write data per write port.
REQ-011 SHALL have port rs_addr, input, [NRD][RAW], meaning source register per read port.
REQ-012 SHALL have port rs_data, output, [NRD][DW], meaning read data per read port.
REQ-013 SHALL have port rs_busy, output, [NRD], meaning the source register has a pending, unwritten result.
REQ-014 SHALL have port iss_en, input, 1, meaning an instruction is issuing that will write iss_addr.
REQ-015 SHALL have port iss_addr, input, [RAW], meaning destination of the issuing instruction.

Function
REQ-016 SHALL hold register 0 hardwired to zero: writes to it are ignored, reads of it return 0, and it is never busy.
REQ-017 SHALL update regs[rd_addr[w]] with rd_data[w] on the rising clk edge when wr_en[w]=1 and rd_addr[w]!=0.
REQ-018 SHALL let the highest-index port win when two write ports target the same address in one cycle.
REQ-019 SHALL make rs_data combinational from rs_addr, with zero cycles of latency.
REQ-020 SHALL forward, when BYPASS=1, the winning same-cycle rd_data to any read port whose rs_addr matches an enabled nonzero rd_addr, instead of returning stored contents.
REQ-021 SHALL return stored (pre-write) contents on a same-cycle match when BYPASS=0.
REQ-022 SHALL keep one busy bit per register in a scoreboard.
REQ-023 SHALL set busy[iss_addr] at the clock edge when iss_en=1 and iss_addr!=0.
REQ-024 SHALL clear busy[rd_addr[w]] at the clock edge when wr_en[w]=1.
REQ-025 SHALL let the set win when a set and a clear hit the same register in one cycle, so the newer writer stays pending.
REQ-026 SHALL drive rs_busy[r] = busy[rs_addr[r]].
REQ-027 SHALL, when BYPASS=1, mask rs_busy[r] to 0 in a cycle where an enabled write matches rs_addr[r].
REQ-028 SHALL drive rs_busy=0 for rs_addr=0.
REQ-029 SHALL perform no check on writes to non-busy registers; they update data and leave busy at 0.

Reset
REQ-030 SHALL, while rst_n=0, asynchronously clear all registers and all busy bits.
REQ-031 SHALL therefore present rs_data=0 and rs_busy=0 during reset.
REQ-032 SHALL discard any issue or write that coincides with reset assertion.
REQ-033 SHALL resume on the first clk edge after rst_n deasserts.

Structure
REQ-034 SHALL place default parameter constants (DW, NREG, NRD, NWR) and the rf_waddr_t/rf_data_t typedefs in the shared package rf_pkg.
REQ-035 SHALL implement the busy-bit array with set/clear priority as the sub-module rf_scoreboard, instantiated once.
REQ-036 SHALL generate read ports and write ports with loops; no port-count-specific hand-written logic.

Verification
REQ-037 SHALL check reset: assert rst_n=0 mid-run after writing x5=0xDEAD -> rs_data for x5 reads 0 and rs_busy=0 immediately, without waiting for a clk edge.
REQ-038 SHALL check bypass with BYPASS=1: wr_en[0]=1, rd_addr=7, rd_data=0x1234 and rs_addr[1]=7 in the same cycle -> rs_data[1]=0x1234 and rs_busy[1]=0; repeated with BYPASS=0 -> old value is returned.
REQ-039 SHALL check x0: write 0xFFFF_FFFF to x0 and issue to x0 -> rs_data=0 and rs_busy=0 on every subsequent read.
REQ-040 SHALL check the scoreboard: iss_en with iss_addr=3 -> rs_busy for x3 is 1 from the next cycle; a write to x3 with 0xA5 -> the following cycle shows busy=0 and data=0xA5.
REQ-041 SHALL check set/clear collision: x3 busy, then iss_addr=3 and a write to x3 in the same cycle -> busy for x3 stays 1 and data=written value.
REQ-042 SHALL check dual-write conflict with NWR=2: both ports write x9, with 0x11 on port 0 and 0x22 on port 1 -> x9=0x22 and forwarded read=0x22.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared constants and types for the multi-ported register file.
package rf_pkg;

  localparam int RF_DW   = 32;
  localparam int RF_NREG = 32;
  localparam int RF_NRD  = 2;
  localparam int RF_NWR  = 1;
  localparam int RF_RAW  = $clog2(RF_NREG);

  typedef logic [RF_RAW-1:0] rf_waddr_t;
  typedef logic [RF_DW-1:0]  rf_data_t;

endpackage

// File: rtl/rf_scoreboard.sv
// One pending-result bit per register.
// A same-cycle set beats a clear, so a newly issued writer stays pending.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter  int NREG = RF_NREG,
  parameter  int NWR  = RF_NWR,
  localparam int RAW  = $clog2(NREG)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     set_en_i,
  input  logic [RAW-1:0]           set_addr_i,
  input  logic [NWR-1:0]           clr_en_i,
  input  logic [NWR-1:0][RAW-1:0]  clr_addr_i,
  output logic [NREG-1:0]          busy_o
);

  logic [NREG-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    for (int w = 0; w < NWR; w++) begin
      if (clr_en_i[w]) busy_d[clr_addr_i[w]] = 1'b0;
    end
    if (set_en_i && (set_addr_i != '0)) busy_d[set_addr_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/rf_mport.sv
// Multi-ported register file with x0 hardwired to zero, optional
// write-to-read forwarding and a busy-bit scoreboard per register.
module rf_mport
  import rf_pkg::*;
#(
  parameter  int DW     = RF_DW,
  parameter  int NREG   = RF_NREG,
  parameter  int NRD    = RF_NRD,
  parameter  int NWR    = RF_NWR,
  parameter  int BYPASS = 1,
  localparam int RAW    = $clog2(NREG)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NWR-1:0]           wr_en,
  input  logic [NWR-1:0][RAW-1:0]  rd_addr,
  input  logic [NWR-1:0][DW-1:0]   rd_data,
  input  logic [NRD-1:0][RAW-1:0]  rs_addr,
  output logic [NRD-1:0][DW-1:0]   rs_data,
  output logic [NRD-1:0]           rs_busy,
  input  logic                     iss_en,
  input  logic [RAW-1:0]           iss_addr
);

  logic [NREG-1:0][DW-1:0] regs_q, regs_d;
  logic [NREG-1:0]         busy;
  logic [NWR-1:0]          wr_valid;

  for (genvar w = 0; w < NWR; w++) begin : g_wr
    assign wr_valid[w] = wr_en[w] && (rd_addr[w] != '0);
  end

  // Ascending port order lets the highest-index port win an address clash.
  always_comb begin
    regs_d = regs_q;
    for (int w = 0; w < NWR; w++) begin
      if (wr_valid[w]) regs_d[rd_addr[w]] = rd_data[w];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) regs_q <= '0;
    else        regs_q <= regs_d;
  end

  rf_scoreboard #(
    .NREG (NREG),
    .NWR  (NWR)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_en_i   (iss_en),
    .set_addr_i (iss_addr),
    .clr_en_i   (wr_en),
    .clr_addr_i (rd_addr),
    .busy_o     (busy)
  );

  // Forwarding is suppressed during reset so outputs read zero immediately.
  for (genvar r = 0; r < NRD; r++) begin : g_rd
    logic          hit;
    logic [DW-1:0] fwd;

    always_comb begin
      hit = 1'b0;
      fwd = '0;
      for (int w = 0; w < NWR; w++) begin
        if ((BYPASS != 0) && rst_n && wr_valid[w] && (rd_addr[w] == rs_addr[r])) begin
          hit = 1'b1;
          fwd = rd_data[w];
        end
      end
    end

    assign rs_data[r] = (rs_addr[r] == '0) ? {DW{1'b0}} :
                        hit                ? fwd        : regs_q[rs_addr[r]];
    assign rs_busy[r] = (rs_addr[r] != '0) && busy[rs_addr[r]] && !hit;
  end

endmodule

// File: tb/tb_rf_mport.sv
// Directed bench for rf_mport: a forwarding and a non-forwarding instance
// driven by the same two-write-port, two-read-port stimulus.
module tb_rf_mport;
  import rf_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [1:0]           wr_en;
  logic [1:0][4:0]      rd_addr;
  logic [1:0][31:0]     rd_data;
  logic [1:0][4:0]      rs_addr;
  logic                 iss_en;
  logic [4:0]           iss_addr;
  logic [1:0][31:0]     rs_data_b, rs_data_n;
  logic [1:0]           rs_busy_b, rs_busy_n;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        ie;
    logic [4:0]  ia;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] d0;
    logic        b0;
    logic [31:0] d1;
    logic        b1;
    logic [31:0] n0;
    logic        nb0;
    logic [31:0] n1;
    logic        nb1;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  rf_mport #(.DW(32), .NREG(32), .NRD(2), .NWR(2), .BYPASS(1)) u_byp (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rs_addr(rs_addr), .rs_data(rs_data_b), .rs_busy(rs_busy_b),
    .iss_en(iss_en), .iss_addr(iss_addr)
  );

  rf_mport #(.DW(32), .NREG(32), .NRD(2), .NWR(2), .BYPASS(0)) u_nobyp (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rs_addr(rs_addr), .rs_data(rs_data_n), .rs_busy(rs_busy_n),
    .iss_en(iss_en), .iss_addr(iss_addr)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = '0; rd_addr = '0; rd_data = '0; iss_en = 1'b0; iss_addr = '0;
  endtask

  initial begin
    rf_data_t k;
    idle();
    rs_addr = '0;
    rst_n   = 1'b0;
    #2;
    rs_addr[0] = 5'd5; rs_addr[1] = 5'd3;
    #1;
    check("reset_data", rs_data_b[0], 32'h0);
    check("reset_busy", {31'h0, rs_busy_b[1]}, 32'h0);
    #9 rst_n = 1'b1;
    step();

    //            we    wa0  wd0            wa1   wd1           ie ia  ra0  ra1  d0            b0 d1            b1 n0            nb0 n1            nb1
    vecs.push_back('{2'b01, 5,  32'hDEAD,     0,  32'h0,        0, 0,  5,   0,   32'hDEAD,     0, 32'h0,        0, 32'h0,        0, 32'h0,        0});
    vecs.push_back('{2'b00, 0,  32'h0,        0,  32'h0,        1, 3,  5,   3,   32'hDEAD,     0, 32'h0,        0, 32'hDEAD,     0, 32'h0,        0});
    vecs.push_back('{2'b00, 0,  32'h0,        0,  32'h0,        0, 0,  3,   5,   32'h0,        1, 32'hDEAD,     0, 32'h0,        1, 32'hDEAD,     0});
    vecs.push_back('{2'b01, 3,  32'hA5,       0,  32'h0,        0, 0,  3,   7,   32'hA5,       0, 32'h0,        0, 32'h0,        1, 32'h0,        0});
    vecs.push_back('{2'b00, 0,  32'h0,        0,  32'h0,        0, 0,  3,   3,   32'hA5,       0, 32'hA5,       0, 32'hA5,       0, 32'hA5,       0});
    vecs.push_back('{2'b01, 7,  32'h1234,     0,  32'h0,        0, 0,  3,   7,   32'hA5,       0, 32'h1234,     0, 32'hA5,       0, 32'h0,        0});
    vecs.push_back('{2'b00, 0,  32'h0,        0,  32'h0,        1, 3,  7,   3,   32'h1234,     0, 32'hA5,       0, 32'h1234,     0, 32'hA5,       0});
    vecs.push_back('{2'b01, 3,  32'hBEEF,     0,  32'h0,        1, 3,  3,   0,   32'hBEEF,     0, 32'h0,        0, 32'hA5,       1, 32'h0,        0});
    vecs.push_back('{2'b00, 0,  32'h0,        0,  32'h0,        0, 0,  3,   7,   32'hBEEF,     1, 32'h1234,     0, 32'hBEEF,     1, 32'h1234,     0});
    vecs.push_back('{2'b11, 0,  32'hFFFFFFFF, 0,  32'hFFFFFFFF, 1, 0,  0,   0,   32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,        0});
    vecs.push_back('{2'b00, 0,  32'h0,        0,  32'h0,        0, 0,  0,   3,   32'h0,        0, 32'hBEEF,     1, 32'h0,        0, 32'hBEEF,     1});
    vecs.push_back('{2'b11, 9,  32'h11,       9,  32'h22,       0, 0,  9,   9,   32'h22,       0, 32'h22,       0, 32'h0,        0, 32'h0,        0});
    vecs.push_back('{2'b00, 0,  32'h0,        0,  32'h0,        0, 0,  9,   9,   32'h22,       0, 32'h22,       0, 32'h22,       0, 32'h22,       0});
    vecs.push_back('{2'b11, 3,  32'h77,       10, 32'h55,       0, 0,  3,   10,  32'h77,       0, 32'h55,       0, 32'hBEEF,     1, 32'h0,        0});
    vecs.push_back('{2'b00, 0,  32'h0,        0,  32'h0,        0, 0,  3,   10,  32'h77,       0, 32'h55,       0, 32'h77,       0, 32'h55,       0});

    foreach (vecs[i]) begin
      wr_en      = vecs[i].we;
      rd_addr[0] = vecs[i].wa0; rd_data[0] = vecs[i].wd0;
      rd_addr[1] = vecs[i].wa1; rd_data[1] = vecs[i].wd1;
      iss_en     = vecs[i].ie;  iss_addr   = vecs[i].ia;
      rs_addr[0] = vecs[i].ra0; rs_addr[1] = vecs[i].ra1;
      #1;
      check($sformatf("v%0d_byp_d0", i), rs_data_b[0], vecs[i].d0);
      check($sformatf("v%0d_byp_b0", i), {31'h0, rs_busy_b[0]}, {31'h0, vecs[i].b0});
      check($sformatf("v%0d_byp_d1", i), rs_data_b[1], vecs[i].d1);
      check($sformatf("v%0d_byp_b1", i), {31'h0, rs_busy_b[1]}, {31'h0, vecs[i].b1});
      check($sformatf("v%0d_nob_d0", i), rs_data_n[0], vecs[i].n0);
      check($sformatf("v%0d_nob_b0", i), {31'h0, rs_busy_n[0]}, {31'h0, vecs[i].nb0});
      check($sformatf("v%0d_nob_d1", i), rs_data_n[1], vecs[i].n1);
      check($sformatf("v%0d_nob_b1", i), {31'h0, rs_busy_n[1]}, {31'h0, vecs[i].nb1});
      step();
    end

    // Mid-run reset: x5 holds 0xDEAD and x12 is pending.
    idle();
    iss_en = 1'b1; iss_addr = 5'd12;
    step();
    idle();
    rs_addr[0] = 5'd5; rs_addr[1] = 5'd12;
    #1;
    check("pre_rst_x5", rs_data_b[0], 32'hDEAD);
    check("pre_rst_busy12", {31'h0, rs_busy_b[1]}, 32'h1);
    wr_en = 2'b01; rd_addr[0] = 5'd5; rd_data[0] = 32'h1111;
    iss_en = 1'b1; iss_addr = 5'd13;
    #1;
    check("pre_rst_fwd", rs_data_b[0], 32'h1111);
    rst_n = 1'b0;
    #1;
    check("rst_async_byp_d0", rs_data_b[0], 32'h0);
    check("rst_async_nob_d0", rs_data_n[0], 32'h0);
    check("rst_async_byp_b1", {31'h0, rs_busy_b[1]}, 32'h0);
    check("rst_async_nob_b1", {31'h0, rs_busy_n[1]}, 32'h0);
    step();
    check("rst_edge_byp_d0", rs_data_b[0], 32'h0);
    #3;
    rst_n = 1'b1;
    idle();
    rs_addr[0] = 5'd5; rs_addr[1] = 5'd13;
    #1;
    check("post_rst_x5", rs_data_n[0], 32'h0);
    check("post_rst_busy13", {31'h0, rs_busy_b[1]}, 32'h0);
    step();
    check("post_rst_x5_later", rs_data_b[0], 32'h0);
    check("post_rst_busy13_later", {31'h0, rs_busy_n[1]}, 32'h0);

    k = 32'h2222;
    wr_en = 2'b01; rd_addr[0] = 5'd5; rd_data[0] = k;
    step();
    idle();
    #1;
    check("resume_byp_x5", rs_data_b[0], k);
    check("resume_nob_x5", rs_data_n[0], k);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
